// File: rtl/irrigation_status_matrix_scanner.sv
// irrigation_status_matrix_scanner: column-multiplexed LED matrix driver showing a frame-stable,
// optionally blinking status glyph.
module irrigation_status_matrix_scanner #(
   parameter int N_COLS       = 5,
   parameter int N_ROWS       = 7,
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 50
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [1:0]        irrigation_status,
   output logic [N_COLS-1:0] columns_n,
   output logic [N_ROWS-1:0] rows_values,
   output logic              frame_start
);
   localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(N_COLS);
   localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0]     pre_q, pre_d;
   logic [CW-1:0]     col_q, col_d;
   logic [1:0]        status_q, status_d, st_eff;
   logic [BW-1:0]     cnt_q, cnt_d;
   logic              phase_q, phase_d, dark_q, dark_d, dark_eff;
   logic [N_COLS-1:0] cols_q, cols_d;
   logic [N_ROWS-1:0] rows_q, rows_d;
   logic              fs_q, fs_d, pre_wrap, cnt_last, is_err;

   function automatic logic [6:0] glyph(input logic [1:0] s, input logic [CW-1:0] c);
      logic [34:0] g;
      int ci;
      ci = int'(c);
      g  = s == 2'b00 ? {5{7'h08}} :
           s == 2'b01 ? {7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E} :
           s == 2'b10 ? {7'h7A, 7'h49, 7'h49, 7'h41, 7'h3E} :
                        {7'h63, 7'h14, 7'h08, 7'h14, 7'h63};
      return ci < 5 ? g[ci*7 +: 7] : 7'h00;
   endfunction

   // cnt/phase describe the next error frame; dark_q freezes the decision for the current frame
   always_comb begin
      fs_d      = enable && pre_q == '0 && col_q == '0;
      is_err    = irrigation_status == 2'b11;
      st_eff    = fs_d ? irrigation_status : status_q;
      dark_eff  = fs_d ? (is_err && phase_q) : dark_q;
      pre_wrap  = pre_q == PW'(SCAN_DIV - 1);
      cnt_last  = cnt_q == BW'(BLINK_FRAMES - 1);
      pre_d     = (!enable || pre_wrap) ? '0 : pre_q + PW'(1);
      col_d     = !enable ? '0 : !pre_wrap ? col_q : col_q == CW'(N_COLS - 1) ? '0 : col_q + CW'(1);
      status_d  = st_eff;
      dark_d    = enable && dark_eff;
      cnt_d     = !enable ? '0 : !fs_d ? cnt_q : (!is_err || cnt_last) ? '0 : cnt_q + BW'(1);
      phase_d   = !enable ? 1'b0 : !fs_d ? phase_q : is_err && (phase_q ^ cnt_last);
      cols_d    = enable ? ~(N_COLS'(1) << col_q) : '1;
      rows_d    = '0;
      rows_d[6:0] = (enable && !dark_eff) ? glyph(st_eff, col_q) : 7'h00;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q    <= '0;
         col_q    <= '0;
         status_q <= 2'b00;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
         dark_q   <= 1'b0;
         cols_q   <= '1;
         rows_q   <= '0;
         fs_q     <= 1'b0;
      end else begin
         pre_q    <= pre_d;
         col_q    <= col_d;
         status_q <= status_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         dark_q   <= dark_d;
         cols_q   <= cols_d;
         rows_q   <= rows_d;
         fs_q     <= fs_d;
      end
   end

   assign columns_n   = cols_q;
   assign rows_values = rows_q;
   assign frame_start = fs_q;
endmodule

// File: tb/tb_irrigation_status_matrix_scanner.sv
// tb_irrigation_status_matrix_scanner: queue scoreboard bench for the matrix scanner,
// with a 5x7 instance and a 6x8 instance.
module tb_irrigation_status_matrix_scanner;
   logic       clk = 1'b0, reset = 1'b1, enable = 1'b1;
   logic [1:0] st = 2'b01, st2 = 2'b01;
   logic [4:0] c1;
   logic [6:0] r1;
   logic       f1;
   logic [5:0] c2;
   logic [7:0] r2;
   logic       f2;

   always #5 clk = ~clk;

   irrigation_status_matrix_scanner #(.N_COLS(5), .N_ROWS(7), .SCAN_DIV(2), .BLINK_FRAMES(2)) u1 (
      .clk(clk), .reset(reset), .enable(enable), .irrigation_status(st),
      .columns_n(c1), .rows_values(r1), .frame_start(f1));

   irrigation_status_matrix_scanner #(.N_COLS(6), .N_ROWS(8), .SCAN_DIV(2), .BLINK_FRAMES(2)) u2 (
      .clk(clk), .reset(reset), .enable(enable), .irrigation_status(st2),
      .columns_n(c2), .rows_values(r2), .frame_start(f2));

   typedef struct {
      int          cyc;
      int          d;
      logic [7:0]  c;
      logic [7:0]  r;
      logic        f;
      string       nm;
   } item_t;

   item_t q[$];
   int tests = 0, fails = 0, ecount = 0, base = 0;

   task automatic chk(input string nm, input logic [7:0] ac, input logic [7:0] ar, input logic af,
                      input logic [7:0] ec, input logic [7:0] er, input logic ef);
      tests++;
      if ({ac, ar, af} !== {ec, er, ef}) begin
         fails++;
         $display("FAIL %s: got cols=%h rows=%h fs=%b, want cols=%h rows=%h fs=%b",
                  nm, ac, ar, af, ec, er, ef);
      end
   endtask

   task automatic ex(input int d, input int k, input logic [7:0] c, input logic [7:0] r,
                     input logic f, input string nm);
      q.push_back('{base + k, d, c, r, f, nm});
   endtask

   task automatic at(input int n);
      while (ecount < base + n) @(negedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      ecount++;
      for (int i = 0; i < q.size();) begin
         if (q[i].cyc == ecount) begin
            if (q[i].d == 1) chk(q[i].nm, {3'b0, c1}, {1'b0, r1}, f1, q[i].c, q[i].r, q[i].f);
            else             chk(q[i].nm, {2'b0, c2}, r2, f2, q[i].c, q[i].r, q[i].f);
            q.delete(i);
         end else if (q[i].cyc < ecount) begin
            tests++;
            fails++;
            $display("FAIL %s: missed at edge %0d, required edge %0d", q[i].nm, ecount, q[i].cyc);
            q.delete(i);
         end else i++;
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_state", {3'b0, c1}, {1'b0, r1}, f1, 8'h1F, 8'h00, 1'b0);
      reset = 1'b0;
      base  = ecount;
      ex(1, 1,  8'h1E, 8'h7E, 1'b1, "a_col0_e1");
      ex(1, 2,  8'h1E, 8'h7E, 1'b0, "a_col0_e2");
      ex(1, 3,  8'h1D, 8'h11, 1'b0, "a_col1");
      ex(1, 5,  8'h1B, 8'h11, 1'b0, "hold_col2");
      ex(1, 7,  8'h17, 8'h11, 1'b0, "hold_col3");
      ex(1, 9,  8'h0F, 8'h7E, 1'b0, "hold_col4");
      ex(1, 11, 8'h1E, 8'h3E, 1'b1, "g_new_frame");
      ex(1, 13, 8'h1D, 8'h41, 1'b0, "g_col1");
      ex(2, 1,  8'h3E, 8'h7E, 1'b1, "w6_col0");
      ex(2, 9,  8'h2F, 8'h7E, 1'b0, "w6_col4");
      ex(2, 11, 8'h1F, 8'h00, 1'b0, "w6_col5_a");
      ex(2, 12, 8'h1F, 8'h00, 1'b0, "w6_col5_b");
      ex(2, 13, 8'h3E, 8'h7E, 1'b1, "w6_wrap");
      ex(2, 25, 8'h3E, 8'h7E, 1'b1, "w6_frame2");
      ex(1, 21, 8'h1E, 8'h63, 1'b1, "x_f0");
      ex(1, 31, 8'h1E, 8'h63, 1'b1, "x_f1");
      ex(1, 41, 8'h1E, 8'h00, 1'b1, "x_f2_dark");
      ex(1, 43, 8'h1D, 8'h00, 1'b0, "x_f2_scan");
      ex(1, 51, 8'h1E, 8'h00, 1'b1, "x_f3_dark");
      ex(1, 61, 8'h1E, 8'h63, 1'b1, "x_f4");
      ex(1, 63, 8'h1D, 8'h14, 0, "x_f4_col1");
      ex(1, 71, 8'h1E, 8'h08, 1'b1, "dash_f0");
      ex(1, 81, 8'h1E, 8'h08, 1'b1, "dash_f1");
      ex(1, 83, 8'h1D, 8'h08, 1'b0, "dash_col1");
      at(4);
      st = 2'b10;
      at(14);
      st = 2'b11;
      at(62);
      st = 2'b00;
      at(90);
      base = ecount;
      st   = 2'b01;
      ex(1, 1,  8'h1E, 8'h7E, 1'b1, "en_frame");
      ex(1, 7,  8'h1F, 8'h00, 1'b0, "dis_a");
      ex(1, 8,  8'h1F, 8'h00, 1'b0, "dis_b");
      ex(1, 10, 8'h1E, 8'h7E, 1'b1, "reen_first");
      ex(1, 12, 8'h1D, 8'h11, 1'b0, "reen_col1");
      ex(1, 15, 8'h1B, 8'h11, 1'b0, "pre_rst_col2");
      at(6);
      enable = 1'b0;
      at(9);
      enable = 1'b1;
      at(15);
      #2 reset = 1'b1;
      #1 chk("async_reset", {3'b0, c1}, {1'b0, r1}, f1, 8'h1F, 8'h00, 1'b0);
      st = 2'b10;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      base  = ecount;
      ex(1, 1, 8'h1E, 8'h3E, 1'b1, "post_rst_col0");
      ex(1, 3, 8'h1D, 8'h41, 1'b0, "post_rst_col1");
      at(6);
      foreach (q[i]) begin
         tests++;
         fails++;
         $display("FAIL %s: never checked, required edge %0d", q[i].nm, q[i].cyc);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
